pipe_rr_issue_ctrl: RTL and testbench

//  Shares one free-running, fixed-latency, non-stallable compute pipeline between NREQ requesters.

---
 rtl/pipe_rr_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_rr_issue_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency, non-stallable pipeline between NREQ requesters.
// Tracks {valid,id} alongside the pipeline and buffers results in a credit-protected output FIFO.

module pipe_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);
  logic [IDW-1:0] idx;

  // Walk offsets from the top down so the smallest offset from ptr wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (gnt_any) gnt_oh[gnt_id] = 1'b1;
  end
endmodule

module pipe_rr_issue_ctrl #(
  parameter int NREQ       = 4,
  parameter int W          = 32,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    pipe_in_valid,
  output logic [W-1:0]            pipe_in_data,
  input  logic [W-1:0]            pipe_out_data,
  output logic                    resp_valid,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [W-1:0]            resp_data,
  input  logic                    resp_ready
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } resp_t;

  logic [NREQ-1:0][W-1:0] req_vec;
  logic [CW-1:0]          cnt;
  logic [IDW-1:0]         rr_ptr;
  logic                   can_issue;
  logic [NREQ-1:0]        gnt_oh;
  logic [IDW-1:0]         gnt_id;
  logic                   gnt_any;
  logic                   issue;
  logic                   pop;
  logic                   push;
  logic                   full;
  resp_t                  push_ent;
  resp_t                  head;

  logic [LATENCY-1:0]           vld_pipe;
  logic [LATENCY-1:0][IDW-1:0]  id_pipe;

  resp_t           mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  assign req_vec = req_data;

  // Credits cover in-flight work plus queued results, so a full FIFO can never be overrun.
  assign can_issue = !rst && (cnt < CW'(FIFO_DEPTH));

  pipe_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (can_issue),
    .gnt_oh  (gnt_oh),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready     = gnt_oh;
  assign issue         = gnt_any;
  assign pipe_in_valid = issue;
  assign pipe_in_data  = issue ? req_vec[gnt_id] : '0;

  assign resp_valid = (occ != '0);
  assign full       = (occ == CW'(FIFO_DEPTH));
  assign pop        = resp_valid && resp_ready;
  assign push       = vld_pipe[LATENCY-1];
  assign push_ent   = '{id: id_pipe[LATENCY-1], data: pipe_out_data};
  assign head       = mem[rd_ptr];
  assign resp_id    = resp_valid ? head.id   : '0;
  assign resp_data  = resp_valid ? head.data : '0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   cnt <= CW'(cnt + 1'b1);
        2'b01:   cnt <= CW'(cnt - 1'b1);
        default: cnt <= cnt;
      endcase
      if (issue) rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_id + 1'b1);
    end
  end

  // Id tracking runs in lockstep with the pipeline; stage LATENCY-1 lines up with pipe_out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= issue;
      id_pipe[0]  <= gnt_id;
      for (int s = 1; s < LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem[e] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= CW'(occ + 1'b1);
        2'b01:   occ <= CW'(occ - 1'b1);
        default: occ <= occ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop));

endmodule

// File: tb/tb_pipe_rr_issue_ctrl.sv
// Bench for pipe_rr_issue_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_rr_issue_ctrl;
  localparam int NREQ = 4, W = 32, LAT = 3, DEP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [W-1:0]    d [NREQ];
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            pipe_in_valid;
  logic [W-1:0]    pipe_in_data;
  logic [W-1:0]    pipe_out_data;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [W-1:0]    resp_data;
  logic            resp_ready;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit model_on = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = d[i];
  end

  // Pipeline stand-in: free-running delay of LAT cycles, result = operand + 3.
  logic [W-1:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= pipe_in_data;
    for (int s = 1; s < LAT; s++) dl[s] <= dl[s-1];
  end
  assign pipe_out_data = dl[LAT-1] + 32'd3;

  pipe_rr_issue_ctrl #(.NREQ(NREQ), .W(W), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
    end
  endtask

  // Reference model: plain queues of in-flight operations and queued results.
  typedef struct { int id; logic [W-1:0] x; int due; } fl_t;
  typedef struct { int id; logic [W-1:0] r; } rs_t;
  fl_t infl[$];
  rs_t rq[$];
  int  rr = 0;

  always @(negedge clk) begin : cmp_proc
    int gid, cred;
    bit gv;
    logic [NREQ-1:0] eg;
    logic [W-1:0] ex;
    gid = 0; gv = 0; eg = '0; ex = '0;
    if (rst) begin
      chk("m_rst_req_ready", 32'(req_ready), 32'd0);
      chk("m_rst_in_valid", 32'(pipe_in_valid), 32'd0);
      if (model_on) chk("m_rst_resp_valid", 32'(resp_valid), rq.size() > 0 ? 32'd1 : 32'd0);
      infl.delete(); rq.delete(); rr = 0; model_on = 1;
    end else if (model_on) begin
      cred = infl.size() + rq.size();
      if (cred < DEP)
        for (int k = 0; k < NREQ; k++)
          if (!gv && req_valid[(rr + k) % NREQ]) begin gv = 1; gid = (rr + k) % NREQ; end
      if (gv) begin eg[gid] = 1'b1; ex = d[gid]; end
      chk("m_req_ready", 32'(req_ready), 32'(eg));
      chk("m_in_valid", 32'(pipe_in_valid), 32'(gv));
      chk("m_in_data", pipe_in_data, ex);
      chk("m_resp_valid", 32'(resp_valid), rq.size() > 0 ? 32'd1 : 32'd0);
      chk("m_resp_id", 32'(resp_id), rq.size() > 0 ? 32'(rq[0].id) : 32'd0);
      chk("m_resp_data", resp_data, rq.size() > 0 ? rq[0].r : 32'd0);
      if (rq.size() > 0 && resp_ready) void'(rq.pop_front());
      if (infl.size() > 0 && infl[0].due == cyc) begin
        rq.push_back('{infl[0].id, infl[0].x + 32'd3});
        void'(infl.pop_front());
      end
      if (gv) begin
        infl.push_back('{gid, ex, cyc + LAT});
        rr = (gid + 1) % NREQ;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) d[i] = '0;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; idle(); resp_ready = 1'b0;
    step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) d[i] = 32'(i + 1);
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_in_valid", 32'(pipe_in_valid), 32'd0);
    end
    step(); rst = 1'b0; idle(); #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);

    // Single request: issue c0, result visible c4 only.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      step(); idle(); resp_ready = 1'b1;
      if (c == 0) begin req_valid = 4'b0001; d[0] = 32'd5; end
      #1;
      if (c == 0) chk("t1_grant", 32'(req_ready), 32'b0001);
      chk("t1_resp_valid", 32'(resp_valid), 32'(c == 4));
      if (c == 4) begin
        chk("t1_resp_id", 32'(resp_id), 32'd0);
        chk("t1_resp_data", resp_data, 32'd8);
      end
    end

    // Round robin: credits run out at c4 (no pop bypass), first pop frees the c5 grant, ptr wraps to 0.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step(); idle(); resp_ready = 1'b1;
      if (c <= 5) begin
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) d[i] = 32'(10 * i);
      end
      #1;
      if (c <= 3) chk("t2_grant", 32'(req_ready), 32'(1 << c));
      if (c == 4) chk("t2_no_credit", 32'(req_ready), 32'd0);
      if (c == 5) chk("t2_wrap", 32'(req_ready), 32'b0001);
      if (c >= 4 && c <= 7) begin
        chk("t2_resp_valid", 32'(resp_valid), 32'd1);
        chk("t2_resp_id", 32'(resp_id), 32'(c - 4));
        chk("t2_resp_data", resp_data, 32'(10 * (c - 4) + 3));
      end
      if (c == 8) chk("t2_gap", 32'(resp_valid), 32'd0);
      if (c == 9) chk("t2_last", resp_data, 32'd3);
    end

    // Backpressure, then drain with concurrent issue and pop.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      step(); idle();
      req_valid = 4'b0001; d[0] = 32'(100 + c); resp_ready = (c >= 10);
      #1;
      if (c < 4) chk("t3_issue", 32'(req_ready), 32'b0001);
      if (c >= 4 && c <= 10) chk("t3_stall", 32'(req_ready), 32'd0);
      if (c == 11) chk("t3_resume", 32'(req_ready), 32'b0001);
      if (c >= 10 && c <= 13) chk("t4_order", resp_data, 32'(103 + c - 10));
      if (c == 14) chk("t4_empty", 32'(resp_valid), 32'd0);
      if (c == 15) chk("t4_next", resp_data, 32'd114);
    end
    for (int c = 0; c < 8; c++) begin step(); idle(); resp_ready = 1'b1; end

    // Reset mid-flight discards both issues and rewinds the pointer.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(); idle(); resp_ready = 1'b1;
      if (c <= 2) begin req_valid = 4'b0110; d[1] = 32'd50; d[2] = 32'd60; end
      rst = (c == 2);
      if (c == 3) begin req_valid = 4'b1010; d[1] = 32'd70; d[3] = 32'd90; end
      #1;
      if (c == 0) chk("t5_g0", 32'(req_ready), 32'b0010);
      if (c == 1) chk("t5_g1", 32'(req_ready), 32'b0100);
      if (c == 2) chk("t5_rst_gate", 32'(req_ready), 32'd0);
      if (c == 3) chk("t5_lowest", 32'(req_ready), 32'b0010);
      if (c >= 3) chk("t5_resp_valid", 32'(resp_valid), 32'(c == 7));
      if (c == 7) begin
        chk("t5_resp_id", 32'(resp_id), 32'd1);
        chk("t5_resp_data", resp_data, 32'd73);
      end
    end

    // Hold head stable under resp_ready=0.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step(); idle(); resp_ready = (c >= 9);
      if (c == 0) begin req_valid = 4'b0001; d[0] = 32'd9; end
      #1;
      if (c >= 4 && c <= 9) begin
        chk("t6_valid", 32'(resp_valid), 32'd1);
        chk("t6_id", 32'(resp_id), 32'd0);
        chk("t6_data", resp_data, 32'd12);
      end
      if (c == 10) chk("t6_popped", 32'(resp_valid), 32'd0);
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
